vc_rr_arbiter: RTL and testbench
================================

VC_RR_ARBITER -- requirements
Module: vc_rr_arbiter

Interface
REQ-001 The block SHALL have parameter ARBITER_WIDTH, default 4, giving the number of requesters; legal range 2..16.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 64, giving the watchdog limit in clock cycles; it is used only with VC_ARB_WATCHDOG_EN.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port request, input, ARBITER_WIDTH bits: per-VC request, level-sensitive.
REQ-006 The block SHALL have port release, input, 1 bit: tail flit of the granted packet accepted this cycle.
REQ-007 The block SHALL have port grant, output, ARBITER_WIDTH bits: registered grant, one-hot or all-zero; it is consumed directly by the one-hot-to-binary index encoder downstream.
REQ-008 The block SHALL have port grant_valid, output, 1 bit: high exactly when grant is non-zero.
REQ-009 The block SHALL have port timeout_err, output, 1 bit: single-cycle watchdog pulse.

Function
REQ-010 The block SHALL use two states: IDLE and LOCKED.
REQ-011 In IDLE with request != 0, the block SHALL, at the next edge, load grant with the first set request bit searching upward from pointer ptr with wrap-around, and go to LOCKED; latency is 1 cycle.
REQ-012 In IDLE with request == 0, the block SHALL hold grant = 0 and grant_valid = 0.
REQ-013 In LOCKED, the block SHALL hold grant unchanged regardless of request, including deassertion of the winner's bit (packet lock).
REQ-014 In LOCKED with release = 1, the block SHALL set ptr = (winner index + 1) mod ARBITER_WIDTH and arbitrate in the same edge using the updated ptr and the current request, with the old winner's bit masked for that edge.
REQ-015 On the REQ-014 arbitration, the block SHALL stay LOCKED with the new grant if any other bit of request is set, giving zero bubble between packets.
REQ-016 On the REQ-014 arbitration with no other request set, the block SHALL go to IDLE with grant = 0.
REQ-017 The block SHALL ignore release while in IDLE, changing no state.
REQ-018 grant SHALL never have more than one bit set; grant_valid SHALL equal the OR of grant.
REQ-019 ptr SHALL be log2(ARBITER_WIDTH) bits wide, update only on release in LOCKED, and wrap from ARBITER_WIDTH-1 to 0.

Reset
REQ-020 When reset = 0 at a clock edge, the block SHALL set state = IDLE, grant = 0, grant_valid = 0, ptr = 0, timeout_err = 0, and clear the watchdog counter.
REQ-021 Reset SHALL take priority over release, request and watchdog, including reset asserted mid-packet while LOCKED.
REQ-022 In the first cycle after reset is deasserted, the block SHALL treat requester 0 as highest priority.

Configuration
REQ-023 With macro VC_ARB_WATCHDOG_EN defined, the block SHALL count cycles spent in LOCKED without release, clearing the counter on any release or state change.
REQ-024 With VC_ARB_WATCHDOG_EN defined, when the counter reaches TIMEOUT_CYCLES-1 the block SHALL perform the REQ-014 behaviour as if release = 1 and pulse timeout_err for one cycle.
REQ-025 With VC_ARB_WATCHDOG_EN defined, a real release coinciding with the timeout cycle SHALL be treated as a normal release, with no timeout_err.
REQ-026 Without VC_ARB_WATCHDOG_EN, the block SHALL contain no counter logic and SHALL tie timeout_err to 0.

Structure
REQ-027 The log2 function and the IDLE/LOCKED state encoding SHALL reside in the shared define header, alongside the existing LOG2 macro.
REQ-028 The block SHALL instantiate one combinational sub-module, arbiter_priority_sel, with inputs request and ptr and output a one-hot winner; all registers SHALL stay in vc_rr_arbiter.

Verification
REQ-029 Reset then request=4'b1010 -> after 1 cycle grant=4'b0010, grant_valid=1, and grant holds while request toggles and release=0.
REQ-030 LOCKED on 4'b0010 with request=4'b1011 and release=1 -> next cycle grant=4'b1000 (zero bubble), ptr=2.
REQ-031 Wrap-around: LOCKED on 4'b1000, request=4'b1001, release=1 -> grant=4'b0001, ptr=0.
REQ-032 Single requester: LOCKED on 4'b0100, request=4'b0100, release=1 -> grant=4'b0000, IDLE; the next cycle re-grants 4'b0100.
REQ-033 reset=0 while LOCKED with release=1 -> grant=0, ptr=0; after reset deasserts with request=4'b1111, grant=4'b0001.
REQ-034 With VC_ARB_WATCHDOG_EN and TIMEOUT_CYCLES=8, LOCKED without release -> timeout_err pulses on the 8th LOCKED cycle and the grant moves to the next requester.

Source files
------------

// File: rtl/vc_rr_arbiter_pkg.sv
// Shared types and helpers for the virtual-channel round-robin arbiter.
// Holds the IDLE/LOCKED state encoding, the log2 sizing function and a one-hot index helper.
package vc_rr_arbiter_pkg;

  localparam int unsigned VC_ARB_MAX_WIDTH = 16;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } vc_arb_state_e;

  // Ceiling log2, never less than 1 so a 2-requester pointer still has a bit.
  function automatic int unsigned vc_log2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [3:0] vc_onehot_idx(input logic [VC_ARB_MAX_WIDTH-1:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < VC_ARB_MAX_WIDTH; i++) begin
      if (v[i]) r = r | 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/vc_rr_arbiter_priority_sel.sv
// Combinational rotating-priority selector: first set request bit at or above ptr_i,
// wrapping past the top requester back to 0. Output is one-hot or all-zero.
module arbiter_priority_sel #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [WIDTH-1:0] request_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [WIDTH-1:0] winner_o
);

  int   idx;
  logic found;

  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      idx = int'(ptr_i) + i;
      if (idx >= int'(WIDTH)) idx = idx - int'(WIDTH);
      if (!found && request_i[idx]) begin
        winner_o[idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vc_rr_arbiter.sv
// Packet-locking round-robin arbiter for virtual channels. A grant is held until the tail
// flit releases it; optional watchdog enabled by defining VC_ARB_WATCHDOG_EN.
module vc_rr_arbiter
  import vc_rr_arbiter_pkg::*;
#(
  parameter int unsigned ARBITER_WIDTH  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned PTR_W         = vc_log2(ARBITER_WIDTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ARBITER_WIDTH-1:0] request,
  // "release" is a reserved word in SystemVerilog, hence the suffix.
  input  logic                     release_i,
  output logic [ARBITER_WIDTH-1:0] grant,
  output logic                     grant_valid,
  output logic                     timeout_err,
  output vc_arb_state_e            dbg_state_o,
  output logic [PTR_W-1:0]         dbg_ptr_o
);

  if (ARBITER_WIDTH < 2 || ARBITER_WIDTH > VC_ARB_MAX_WIDTH) begin : g_bad_width
    $error("vc_rr_arbiter: ARBITER_WIDTH out of range 2..16");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("vc_rr_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  vc_arb_state_e              state_q, state_d;
  logic [ARBITER_WIDTH-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]           ptr_q, ptr_d;
  logic [PTR_W-1:0]           ptr_adv, sel_ptr;
  logic [ARBITER_WIDTH-1:0]   sel_req, winner;
  logic [VC_ARB_MAX_WIDTH-1:0] grant_pad;
  logic [3:0]                 win_idx;
  logic                       locked, rel_eff, rearb;

  assign locked = (state_q == ARB_LOCKED);

`ifdef VC_ARB_WATCHDOG_EN
  localparam int unsigned CNT_W = vc_log2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             wd_hit, timeout_q;

  // A real release on the limit cycle wins, so the watchdog only fires without one.
  always_comb begin
    wd_hit   = locked && !release_i && (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    rel_eff  = release_i | wd_hit;
    wd_cnt_d = (locked && !rel_eff) ? wd_cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= wd_hit;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign rel_eff     = release_i;
  assign timeout_err = 1'b0;
`endif

  // On release the old winner is masked and the search restarts just above it.
  always_comb begin
    grant_pad                       = '0;
    grant_pad[ARBITER_WIDTH-1:0]    = grant_q;
    win_idx                         = vc_onehot_idx(grant_pad);
    if (int'(win_idx) == int'(ARBITER_WIDTH) - 1) ptr_adv = '0;
    else                                          ptr_adv = PTR_W'(int'(win_idx) + 1);
    rearb   = locked && rel_eff;
    sel_req = rearb ? (request & ~grant_q) : request;
    sel_ptr = rearb ? ptr_adv : ptr_q;
  end

  arbiter_priority_sel #(
    .WIDTH (ARBITER_WIDTH),
    .PTR_W (PTR_W)
  ) u_sel (
    .request_i (sel_req),
    .ptr_i     (sel_ptr),
    .winner_o  (winner)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      ARB_IDLE: begin
        grant_d = winner;
        state_d = (|winner) ? ARB_LOCKED : ARB_IDLE;
      end
      ARB_LOCKED: begin
        if (rel_eff) begin
          ptr_d   = ptr_adv;
          grant_d = winner;
          state_d = (|winner) ? ARB_LOCKED : ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign dbg_state_o = state_q;
  assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_vc_rr_arbiter.sv
// Bench for vc_rr_arbiter: directed scenarios then random traffic against a
// behavioural round-robin/packet-lock model. Define VC_ARB_WATCHDOG_EN to cover the watchdog.
module tb_vc_rr_arbiter;
  import vc_rr_arbiter_pkg::*;

  localparam int N     = 4;
  localparam int T     = 8;
  localparam int PTR_W = 2;

  logic             clk;
  logic             reset;
  logic [N-1:0]     request;
  logic             rel;
  logic [N-1:0]     grant;
  logic             grant_valid;
  logic             timeout_err;
  vc_arb_state_e    dbg_state;
  logic [PTR_W-1:0] dbg_ptr;

  int checks   = 0;
  int failures = 0;

  // Reference model state: who holds the lock, rotation pointer, watchdog age.
  bit m_locked;
  int m_win;
  int m_ptr;
  int m_cnt;
  bit m_terr;

  vc_rr_arbiter #(
    .ARBITER_WIDTH  (N),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .request     (request),
    .release_i   (rel),
    .grant       (grant),
    .grant_valid (grant_valid),
    .timeout_err (timeout_err),
    .dbg_state_o (dbg_state),
    .dbg_ptr_o   (dbg_ptr)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] req, input int p);
    for (int i = 0; i < N; i++) begin
      if (req[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [N-1:0] req, input logic r, input logic rst_n);
    logic [N-1:0] masked;
    int w;
    bit eff, hit;
    if (!rst_n) begin
      m_locked = 0; m_win = 0; m_ptr = 0; m_cnt = 0; m_terr = 0;
      return;
    end
    eff = r;
    hit = 0;
`ifdef VC_ARB_WATCHDOG_EN
    if (m_locked && !r && m_cnt == T - 1) begin
      hit = 1;
      eff = 1;
    end
`endif
    if (!m_locked) begin
      w = pick(req, m_ptr);
      if (w >= 0) begin m_locked = 1; m_win = w; end
      m_cnt = 0;
    end else if (eff) begin
      m_ptr = (m_win + 1) % N;
      masked = req;
      masked[m_win] = 1'b0;
      w = pick(masked, m_ptr);
      if (w >= 0) m_win = w;
      else        m_locked = 0;
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
    m_terr = hit;
  endtask

  // Driver: apply inputs mid-cycle, advance one edge, then compare everything.
  task automatic step(input logic [N-1:0] req, input logic r, input logic rst_n);
    logic [N-1:0] exp_grant;
    @(negedge clk);
    request = req;
    rel     = r;
    reset   = rst_n;
    model_step(req, r, rst_n);
    @(posedge clk);
    #1;
    exp_grant = m_locked ? N'(1 << m_win) : '0;
    check("grant",       32'(grant),       32'(exp_grant));
    check("grant_valid", 32'(grant_valid), 32'(m_locked));
    check("ptr",         32'(dbg_ptr),     32'(m_ptr));
    check("state",       32'(dbg_state),   32'(m_locked ? ARB_LOCKED : ARB_IDLE));
    check("timeout_err", 32'(timeout_err), 32'(m_terr));
    check("onehot",      32'($countones(grant) <= 1), 32'd1);
  endtask

  initial begin
    request = '0;
    rel     = 1'b0;
    reset   = 1'b0;

    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_ptr",   32'(dbg_ptr), 32'd0);

    // Idle release is ignored
    step(4'b0000, 1'b1, 1'b1);
    check("idle_release", 32'(grant), 32'd0);

    // Grant from pointer 0, then packet lock holds while request wiggles
    step(4'b1010, 1'b0, 1'b1);
    check("first_grant", 32'(grant), 32'b0010);
    check("first_valid", 32'(grant_valid), 32'd1);
    step(4'b0101, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    check("lock_hold", 32'(grant), 32'b0010);

    // Zero-bubble hand-off and wrap-around
    step(4'b1011, 1'b1, 1'b1);
    check("handoff_grant", 32'(grant), 32'b1000);
    check("handoff_ptr",   32'(dbg_ptr), 32'd2);
    step(4'b1001, 1'b1, 1'b1);
    check("wrap_grant", 32'(grant), 32'b0001);
    check("wrap_ptr",   32'(dbg_ptr), 32'd0);

    // Single requester: release drops to IDLE, then re-grants next cycle
    step(4'b0100, 1'b1, 1'b1);
    check("single_lock", 32'(grant), 32'b0100);
    step(4'b0100, 1'b1, 1'b1);
    check("single_idle", 32'(grant), 32'd0);
    step(4'b0100, 1'b0, 1'b1);
    check("single_regrant", 32'(grant), 32'b0100);

    // Reset beats release mid-packet; requester 0 first afterwards
    step(4'b1111, 1'b1, 1'b0);
    check("rst_mid_grant", 32'(grant), 32'd0);
    check("rst_mid_ptr",   32'(dbg_ptr), 32'd0);
    step(4'b1111, 1'b0, 1'b1);
    check("post_rst_grant", 32'(grant), 32'b0001);

`ifdef VC_ARB_WATCHDOG_EN
    step(4'b0011, 1'b0, 1'b0);
    step(4'b0011, 1'b0, 1'b1);
    for (int i = 0; i < T - 1; i++) step(4'b0011, 1'b0, 1'b1);
    check("wd_hold", 32'(grant), 32'b0001);
    step(4'b0011, 1'b0, 1'b1);
    check("wd_pulse", 32'(timeout_err), 32'd1);
    check("wd_move",  32'(grant), 32'b0010);
    step(4'b0011, 1'b0, 1'b1);
    check("wd_single", 32'(timeout_err), 32'd0);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(N'($urandom_range(0, (1 << N) - 1)),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 49) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
